// File: rtl/counter_pkg.sv
// Shared counter definitions: direction encoding and a constant log2 helper.
// Latency: none (package only).
// Backpressure: not applicable.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Smallest r with 2**r >= v; used for elaboration-time width checks.
  function automatic int clog2(input longint v);
    int     r;
    longint p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/updown_counter_mod_if.sv
// Control/status bundle of the up/down modulo counter.
// Latency: none (wires only).
// Backpressure: none; the counter accepts a control word every cycle.
interface updown_counter_mod_if #(
  parameter int WIDTH = 6
) ();
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (output en, up, load, load_val, input q, tc, wrap);
  modport slave  (input en, up, load, load_val, output q, tc, wrap);
endinterface

// File: rtl/updown_counter_next.sv
// Next-state arithmetic of the modulo counter: wrapped +1/-1, saturated load, terminal flags.
// Latency: purely combinational.
// Backpressure: none.
module updown_counter_next #(
  parameter int     WIDTH   = 6,
  parameter longint MODULUS = 64
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_up,
  output logic [WIDTH-1:0] next_down,
  output logic [WIDTH-1:0] load_sat,
  output logic             at_max,
  output logic             at_min
);
  import counter_pkg::*;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic q_is_max;
  logic q_is_min;

  assign q_is_max = (q == MAX_VAL);
  assign q_is_min = (q == '0);

  // Increment/decrement with wrap at the modulus boundaries.
  assign next_up   = q_is_max ? '0 : q + WIDTH'(1);
  assign next_down = q_is_min ? MAX_VAL : q - WIDTH'(1);

  // Out-of-range load values clamp to the top state so q never leaves 0..MODULUS-1.
  assign load_sat = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  // Terminal flags are qualified by direction: only the boundary we are heading
  // towards counts, so the top level can OR them into tc and wrap directly.
  assign at_max = (up == DIR_UP) & q_is_max;
  assign at_min = (up == DIR_DOWN) & q_is_min;
endmodule

// File: rtl/updown_counter_mod.sv
// Synchronous up/down modulo counter with load, enable, cascade tc and registered wrap pulse.
// Latency: q/wrap update one edge after control is sampled; tc is combinational.
// Backpressure: none; every cycle is accepted, cascade through tc -> next en.
module updown_counter_mod #(
  parameter int     WIDTH     = 6,
  parameter longint MODULUS   = 64,
  parameter longint RESET_VAL = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  updown_counter_mod_if.slave bus
);
  import counter_pkg::*;

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  // Reject configurations that could place q outside 0..MODULUS-1.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("updown_counter_mod: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
    $error("updown_counter_mod: MODULUS must be 2..2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset
    $error("updown_counter_mod: RESET_VAL must be < MODULUS");
  end

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic [WIDTH-1:0] next_up;
  logic [WIDTH-1:0] next_down;
  logic [WIDTH-1:0] load_sat;
  logic             at_max;
  logic             at_min;

  updown_counter_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .q         (q_r),
    .up        (bus.up),
    .load_val  (bus.load_val),
    .next_up   (next_up),
    .next_down (next_down),
    .load_sat  (load_sat),
    .at_max    (at_max),
    .at_min    (at_min)
  );

  // Priority: reset, load, count, hold; wrap is set only by a counting edge that crosses a boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r    <= RST_Q;
      wrap_r <= 1'b0;
    end else if (bus.load) begin
      q_r    <= load_sat;
      wrap_r <= 1'b0;
    end else if (bus.en) begin
      if (bus.up == DIR_UP) begin
        q_r    <= next_up;
        wrap_r <= at_max;
      end else begin
        q_r    <= next_down;
        wrap_r <= at_min;
      end
    end else begin
      wrap_r <= 1'b0;
    end
  end

  assign bus.q    = q_r;
  assign bus.wrap = wrap_r;
  // at_max/at_min are already direction-qualified, so their OR is the boundary in the current direction.
  assign bus.tc   = bus.en & ~bus.load & (at_max | at_min);
endmodule

// File: tb/tb_updown_counter_mod.sv
module tb_updown_counter_mod;
  import counter_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  updown_counter_mod_if #(.WIDTH(6)) a_if ();
  updown_counter_mod_if #(.WIDTH(4)) b_if ();
  updown_counter_mod_if #(.WIDTH(4)) lo_if ();
  updown_counter_mod_if #(.WIDTH(4)) hi_if ();

  updown_counter_mod #(.WIDTH(6), .MODULUS(64), .RESET_VAL(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  updown_counter_mod #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave));
  updown_counter_mod #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .bus(lo_if.slave));
  updown_counter_mod #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .bus(hi_if.slave));

  // Cascade: the high stage counts only when the low stage is at its terminal count.
  assign hi_if.en = lo_if.tc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_if.load = 1'b1; a_if.load_val = 6'd9; a_if.en = 1'b1; a_if.up = DIR_UP;
    b_if.load = 1'b0; b_if.en = 1'b1; b_if.up = DIR_DOWN;
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (a_if.q !== 6'd5) begin errors++; $display("FAIL reset_q got %0d expected 5", a_if.q); end
    checks++; if (a_if.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %0b expected 0", a_if.wrap); end
    checks++; if (b_if.q !== 4'd0) begin errors++; $display("FAIL reset_b_q got %0d expected 0", b_if.q); end
    checks++; if (b_if.tc !== 1'b1) begin errors++; $display("FAIL reset_b_tc_down got %0b expected 1", b_if.tc); end
    rst_n = 1'b1; a_if.load = 1'b0; b_if.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (a_if.q !== 6'(6 + i)) begin
        errors++; $display("FAIL post_reset_count[%0d] got %0d expected %0d", i, a_if.q, 6 + i);
      end
    end
    a_if.en = 1'b0;
  endtask

  task automatic test_up_wrap();
    b_if.load = 1'b1; b_if.load_val = 4'd8; b_if.en = 1'b0; b_if.up = DIR_UP;
    tick();
    checks++; if (b_if.q !== 4'd8) begin errors++; $display("FAIL upw_load got %0d expected 8", b_if.q); end
    b_if.load = 1'b0; b_if.en = 1'b1;
    #1;
    checks++; if (b_if.tc !== 1'b0) begin errors++; $display("FAIL upw_tc_at8 got %0b expected 0", b_if.tc); end
    tick();
    checks++; if (b_if.q !== 4'd9) begin errors++; $display("FAIL upw_q9 got %0d expected 9", b_if.q); end
    checks++; if (b_if.tc !== 1'b1) begin errors++; $display("FAIL upw_tc_at9 got %0b expected 1", b_if.tc); end
    checks++; if (b_if.wrap !== 1'b0) begin errors++; $display("FAIL upw_wrap_at9 got %0b expected 0", b_if.wrap); end
    tick();
    checks++; if (b_if.q !== 4'd0) begin errors++; $display("FAIL upw_q0 got %0d expected 0", b_if.q); end
    checks++; if (b_if.wrap !== 1'b1) begin errors++; $display("FAIL upw_wrap_pulse got %0b expected 1", b_if.wrap); end
    tick();
    checks++; if (b_if.q !== 4'd1) begin errors++; $display("FAIL upw_q1 got %0d expected 1", b_if.q); end
    checks++; if (b_if.wrap !== 1'b0) begin errors++; $display("FAIL upw_wrap_end got %0b expected 0", b_if.wrap); end
  endtask

  task automatic test_down_wrap();
    b_if.load = 1'b1; b_if.load_val = 4'd1; b_if.en = 1'b0; b_if.up = DIR_DOWN;
    tick();
    b_if.load = 1'b0; b_if.en = 1'b1;
    tick();
    checks++; if (b_if.q !== 4'd0) begin errors++; $display("FAIL dnw_q0 got %0d expected 0", b_if.q); end
    checks++; if (b_if.tc !== 1'b1) begin errors++; $display("FAIL dnw_tc_at0 got %0b expected 1", b_if.tc); end
    tick();
    checks++; if (b_if.q !== 4'd9) begin errors++; $display("FAIL dnw_q9 got %0d expected 9", b_if.q); end
    checks++; if (b_if.wrap !== 1'b1) begin errors++; $display("FAIL dnw_wrap_pulse got %0b expected 1", b_if.wrap); end
    tick();
    checks++; if (b_if.q !== 4'd8) begin errors++; $display("FAIL dnw_q8 got %0d expected 8", b_if.q); end
    checks++; if (b_if.wrap !== 1'b0) begin errors++; $display("FAIL dnw_wrap_end got %0b expected 0", b_if.wrap); end
  endtask

  task automatic test_load_sat();
    b_if.load = 1'b1; b_if.load_val = 4'd13; b_if.en = 1'b1; b_if.up = DIR_UP;
    tick();
    checks++; if (b_if.q !== 4'd9) begin errors++; $display("FAIL sat_q got %0d expected 9", b_if.q); end
    checks++; if (b_if.tc !== 1'b0) begin errors++; $display("FAIL sat_tc_during_load got %0b expected 0", b_if.tc); end
    b_if.load = 1'b0;
    #1;
    checks++; if (b_if.tc !== 1'b1) begin errors++; $display("FAIL sat_tc_after_load got %0b expected 1", b_if.tc); end
    tick();
    checks++; if (b_if.q !== 4'd0) begin errors++; $display("FAIL sat_wrap_q got %0d expected 0", b_if.q); end
    tick();
    b_if.load = 1'b1; b_if.load_val = 4'd3;
    tick();
    checks++; if (b_if.q !== 4'd3) begin errors++; $display("FAIL midcount_load got %0d expected 3", b_if.q); end
    checks++; if (b_if.wrap !== 1'b0) begin errors++; $display("FAIL midcount_load_wrap got %0b expected 0", b_if.wrap); end
    b_if.load = 1'b0; b_if.en = 1'b0;
  endtask

  task automatic test_dir_hold();
    b_if.load = 1'b1; b_if.load_val = 4'd4;
    tick();
    b_if.load = 1'b0; b_if.en = 1'b1; b_if.up = DIR_UP;
    tick();
    tick();
    checks++; if (b_if.q !== 4'd6) begin errors++; $display("FAIL dir_up2 got %0d expected 6", b_if.q); end
    b_if.up = DIR_DOWN;
    tick();
    checks++; if (b_if.q !== 4'd5) begin errors++; $display("FAIL dir_turn got %0d expected 5", b_if.q); end
    tick();
    tick();
    checks++; if (b_if.q !== 4'd3) begin errors++; $display("FAIL dir_down3 got %0d expected 3", b_if.q); end
    b_if.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (b_if.q !== 4'd3 || b_if.tc !== 1'b0 || b_if.wrap !== 1'b0) begin
        errors++; $display("FAIL hold[%0d] got q=%0d tc=%0b wrap=%0b expected q=3 tc=0 wrap=0",
                           i, b_if.q, b_if.tc, b_if.wrap);
      end
    end
  endtask

  task automatic test_cascade();
    lo_if.load = 1'b1; lo_if.load_val = 4'hF; lo_if.en = 1'b0; lo_if.up = DIR_UP;
    hi_if.load = 1'b1; hi_if.load_val = 4'h0; hi_if.up = DIR_UP;
    tick();
    checks++; if ({hi_if.q, lo_if.q} !== 8'h0F) begin errors++; $display("FAIL casc_load0f got %0h expected 0f", {hi_if.q, lo_if.q}); end
    lo_if.load = 1'b0; hi_if.load = 1'b0; lo_if.en = 1'b1;
    #1;
    checks++; if (lo_if.tc !== 1'b1) begin errors++; $display("FAIL casc_lo_tc got %0b expected 1", lo_if.tc); end
    tick();
    checks++; if ({hi_if.q, lo_if.q} !== 8'h10) begin errors++; $display("FAIL casc_0f_to_10 got %0h expected 10", {hi_if.q, lo_if.q}); end
    lo_if.load = 1'b1; hi_if.load = 1'b1; hi_if.load_val = 4'hF;
    tick();
    lo_if.load = 1'b0; hi_if.load = 1'b0;
    #1;
    checks++; if (hi_if.tc !== 1'b1) begin errors++; $display("FAIL casc_hi_tc got %0b expected 1", hi_if.tc); end
    tick();
    checks++; if ({hi_if.q, lo_if.q} !== 8'h00) begin errors++; $display("FAIL casc_ff_to_00 got %0h expected 00", {hi_if.q, lo_if.q}); end
    checks++; if (lo_if.wrap !== 1'b1 || hi_if.wrap !== 1'b1) begin
      errors++; $display("FAIL casc_wrap got lo=%0b hi=%0b expected lo=1 hi=1", lo_if.wrap, hi_if.wrap);
    end
    tick();
    checks++; if ({hi_if.q, lo_if.q} !== 8'h01) begin errors++; $display("FAIL casc_01 got %0h expected 01", {hi_if.q, lo_if.q}); end
    checks++; if (lo_if.wrap !== 1'b0) begin errors++; $display("FAIL casc_lo_wrap_end got %0b expected 0", lo_if.wrap); end
    lo_if.en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    a_if.en = 1'b0;  a_if.up = DIR_UP;  a_if.load = 1'b0;  a_if.load_val = '0;
    b_if.en = 1'b0;  b_if.up = DIR_UP;  b_if.load = 1'b0;  b_if.load_val = '0;
    lo_if.en = 1'b0; lo_if.up = DIR_UP; lo_if.load = 1'b0; lo_if.load_val = '0;
    hi_if.up = DIR_UP; hi_if.load = 1'b0; hi_if.load_val = '0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_sat();
    test_dir_hold();
    test_cascade();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
